// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS sequencer driving datapath enables, mux selects and memory handshake
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op_3,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_instr
);

    localparam logic [5:0] opRtype = 6'h00;
    localparam logic [5:0] opJ     = 6'h02;
    localparam logic [5:0] opBeq   = 6'h04;
    localparam logic [5:0] opBne   = 6'h05;
    localparam logic [5:0] opAddi  = 6'h08;
    localparam logic [5:0] opAndi  = 6'h0C;
    localparam logic [5:0] opOri   = 6'h0D;
    localparam logic [5:0] opLui   = 6'h0F;
    localparam logic [5:0] opLw    = 6'h23;
    localparam logic [5:0] opSw    = 6'h2B;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        WB_R     = 4'd3,
        EXEC_I   = 4'd4,
        WB_I     = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        WB_MEM   = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11
    } stateType;

    stateType   state;
    stateType   nextState;
    logic [5:0] opR;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            opR   <= 6'h00;
        end else begin
            state <= nextState;
            if (state == DECODE) begin
                opR <= opcode;
            end
        end
    end

    always_comb begin
        nextState     = FETCH;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op_3      = 3'd0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        illegal_instr = 1'b0;

        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                nextState = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded
                alu_src_b = 2'd3;
                case (opcode)
                    opRtype:                        nextState = EXEC_R;
                    opLw, opSw:                     nextState = MEM_ADDR;
                    opAddi, opAndi, opOri, opLui:   nextState = EXEC_I;
                    opBeq, opBne:                   nextState = BRANCH;
                    opJ:                            nextState = JUMP;
                    default: begin
                        nextState     = FETCH;
                        illegal_instr = 1'b1;
                    end
                endcase
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op_3  = 3'd2;
                nextState = WB_R;
            end
            WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                case (opR)
                    opAndi:  alu_op_3 = 3'd6;
                    opOri:   alu_op_3 = 3'd5;
                    opLui:   alu_op_3 = 3'd3;
                    default: alu_op_3 = 3'd0;
                endcase
                nextState = WB_I;
            end
            WB_I: begin
                reg_write = 1'b1;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                nextState = (opR == opLw) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                nextState = mem_ready ? WB_MEM : MEM_RD;
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                iord      = 1'b1;
                nextState = mem_ready ? FETCH : MEM_WR;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op_3  = 3'd1;
                pc_src    = 2'd1;
                pc_write  = ((opR == opBeq) & zero) | ((opR == opBne) & ~zero);
            end
            JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'd2;
            end
            default: nextState = FETCH;
        endcase

        // Reset silences every output in the same cycle, including mid-wait requests
        if (reset) begin
            nextState     = FETCH;
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            iord          = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_src        = 2'd0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'd0;
            alu_op_3      = 3'd0;
            reg_write     = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            illegal_instr = 1'b0;
        end
    end

endmodule
